// File: rtl/core_pkg.sv
// Shared scoreboard types and sizing for the decode/data-fetch hazard logic.
`ifndef GLB_REG_NUM
`define GLB_REG_NUM 32
`endif

package core_pkg;
  localparam int SB_NREGS = `GLB_REG_NUM;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_t;
endpackage

// File: rtl/reg_sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with clear.
// underflow_o is a same-cycle pulse for a decrement that hits zero.
module reg_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic nonzero_o,
  output logic full_o,
  output logic underflow_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign nonzero_o = |cnt_q;
  assign full_o    = &cnt_q;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      // A retirement with no writer outstanding is dropped and reported.
      if (!nonzero_o) underflow_o = 1'b1;
      else            cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between decode and data fetch: per-register writer
// counters gate issue, WB retires them, and a drain sequencer serialises the pipe.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int NREGS = SB_NREGS,
  parameter int REG_W = 5,
  parameter int CNT_W = 2,
  parameter int TOT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [2:0]       issue_src_valid,
  input  logic [REG_W-1:0] issue_src0,
  input  logic [REG_W-1:0] issue_src1,
  input  logic [REG_W-1:0] issue_src2,
  input  logic             issue_dst_valid,
  input  logic [REG_W-1:0] issue_dst,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             flush,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [NREGS-1:0] busy_vec,
  output logic [TOT_W-1:0] inflight,
  output logic             err_underflow
);
  sb_state_t        state_q;
  logic             done_q;
  logic             err_q;
  logic [TOT_W-1:0] inflight_q, inflight_d;

  logic [NREGS-1:0] nz_vec, full_vec, uf_vec, inc_vec, dec_vec;
  logic [REG_W-1:0] src [3];
  logic             src_hz, dst_full, fire;
  logic             inc_hit, dec_hit, same_reg, inc_real, dec_real;

  function automatic logic in_rng(input logic [REG_W-1:0] r);
    return 32'(r) < NREGS;
  endfunction

  assign src[0] = issue_src0;
  assign src[1] = issue_src1;
  assign src[2] = issue_src2;

  always_comb begin
    src_hz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (issue_src_valid[k] && in_rng(src[k]) && nz_vec[src[k]]) src_hz = 1'b1;
    end
    dst_full    = issue_dst_valid && in_rng(issue_dst) && full_vec[issue_dst];
    issue_ready = reset && (state_q == SB_IDLE) && !src_hz && !dst_full;
  end

  assign fire     = issue_valid && issue_ready;
  assign inc_hit  = fire && issue_dst_valid && in_rng(issue_dst) && !flush;
  assign dec_hit  = wb_valid && in_rng(wb_dst) && !flush;
  assign same_reg = inc_hit && dec_hit && (issue_dst == wb_dst);
  // Totals track the counters: a same-register fire+wb cancels, a wb to zero is dropped.
  assign inc_real = inc_hit && !same_reg;
  assign dec_real = dec_hit && !same_reg && nz_vec[wb_dst];

  always_comb begin
    if (flush) inflight_d = '0;
    else       inflight_d = inflight_q + TOT_W'(inc_real) - TOT_W'(dec_real);
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cnt
    assign inc_vec[i] = inc_hit && (issue_dst == REG_W'(i));
    assign dec_vec[i] = dec_hit && (wb_dst == REG_W'(i));

    reg_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i       (clk),
      .rst_ni      (reset),
      .inc_i       (inc_vec[i]),
      .dec_i       (dec_vec[i]),
      .clr_i       (flush),
      .nonzero_o   (nz_vec[i]),
      .full_o      (full_vec[i]),
      .underflow_o (uf_vec[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SB_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_q | (|uf_vec);
      if (flush) begin
        state_q <= SB_IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          SB_IDLE: begin
            done_q <= 1'b0;
            if (drain_req) state_q <= SB_DRAIN;
          end
          SB_DRAIN: begin
            if (inflight_q == '0 && !wb_valid) begin
              state_q <= SB_DONE;
              done_q  <= 1'b1;
            end
          end
          SB_DONE: begin
            state_q <= SB_IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= SB_IDLE;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign drain_done    = done_q;
  assign busy_vec      = nz_vec;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;
endmodule
